mem_access_unit: RTL

- Memory-stage control block directly upstream of the 2K x 16 data memory (11-bit word address, synchronous write, combinational read, 32-bit access spanning words A and A+1).
- Decodes the memory-stage operation and owns the stack pointer (SP).
- Sequences the multi-cycle interrupt-entry and interrupt-return transfers, stalling the pipeline while they run.
- Drives the memory's Address/Write_Data/MW/MR and returns load data, PC and flags to the write-back side.

---
 rtl/mem_access_if.sv | 38 +++
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Memory-stage bus: pipeline-side requests, memory port, and write-back results.
// slave is the access unit; master is whoever drives the stage and models the memory.
interface mem_access_if #(
  parameter int ADDR_W = 11
);
  logic              valid_in;
  logic [2:0]        op;
  logic              is_rti;
  logic [31:0]       ea;
  logic [31:0]       wdata;
  logic [31:0]       pc_in;
  logic [3:0]        flags_in;
  logic [31:0]       Read_Data;
  logic [31:0]       Address;
  logic [31:0]       Write_Data;
  logic              MW;
  logic              MR;
  logic [31:0]       rdata_out;
  logic [31:0]       pc_out;
  logic              pc_load;
  logic [3:0]        flags_out;
  logic              flags_load;
  logic              busy;
  logic [ADDR_W-1:0] sp_out;
  logic              stack_err;

  modport slave (
    input  valid_in, op, is_rti, ea, wdata, pc_in, flags_in, Read_Data,
    output Address, Write_Data, MW, MR, rdata_out, pc_out, pc_load,
           flags_out, flags_load, busy, sp_out, stack_err
  );

  modport master (
    output valid_in, op, is_rti, ea, wdata, pc_in, flags_in, Read_Data,
    input  Address, Write_Data, MW, MR, rdata_out, pc_out, pc_load,
           flags_out, flags_load, busy, sp_out, stack_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage control: LDD/STD decode, stack pointer ownership, and the
// two-cycle interrupt entry/return sequences in front of the 2K x 16 data memory.
module mem_access_unit #(
  parameter int                ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = 11'h7FE
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);

  localparam logic [2:0] OP_LDD  = 3'd1;
  localparam logic [2:0] OP_STD  = 3'd2;
  localparam logic [2:0] OP_PUSH = 3'd3;
  localparam logic [2:0] OP_POP  = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_INT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INT2 = 2'd1,
    ST_RTI2 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [3:0]        flags_q, flags_d;

  logic              is_ldd, is_std;
  logic              do_push, do_pop;
  logic [31:0]       push_val;
  logic              ret_pc, rti_flags;
  logic              int_start, rti_start;
  logic [ADDR_W-1:0] sp_plus2, sp_minus2;

  logic [ADDR_W-1:0] addr_w;
  logic [31:0]       address, write_data, rdata_out, pc_out;
  logic              mw, mr, pc_load, flags_load, busy, stack_err;
  logic [3:0]        flags_out;

  assign sp_plus2  = sp_q + ADDR_W'(2);
  assign sp_minus2 = sp_q - ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sp_q    <= SP_RESET;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      flags_q <= flags_d;
    end
  end

  // Classify the cycle's access; the second half of INT/RTI ignores op/valid_in.
  always_comb begin
    is_ldd    = 1'b0;
    is_std    = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    push_val  = 32'd0;
    ret_pc    = 1'b0;
    rti_flags = 1'b0;
    int_start = 1'b0;
    rti_start = 1'b0;
    unique case (state_q)
      ST_INT2: begin
        do_push  = 1'b1;
        push_val = {28'd0, flags_q};
      end
      ST_RTI2: begin
        do_pop = 1'b1;
        ret_pc = 1'b1;
      end
      default: begin
        if (bus.valid_in) begin
          unique case (bus.op)
            OP_LDD:  is_ldd = 1'b1;
            OP_STD:  is_std = 1'b1;
            OP_PUSH: begin
              do_push  = 1'b1;
              push_val = bus.wdata;
            end
            OP_POP:  do_pop = 1'b1;
            OP_CALL: begin
              do_push  = 1'b1;
              push_val = bus.pc_in;
            end
            OP_RET: begin
              do_pop = 1'b1;
              if (bus.is_rti) begin
                rti_flags = 1'b1;
                rti_start = 1'b1;
              end else begin
                ret_pc = 1'b1;
              end
            end
            OP_INT: begin
              do_push   = 1'b1;
              push_val  = bus.pc_in;
              int_start = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    state_d = ST_IDLE;
    if (int_start) begin
      state_d = ST_INT2;
    end else if (rti_start) begin
      state_d = ST_RTI2;
    end
  end

  always_comb begin
    sp_d    = sp_q;
    flags_d = flags_q;
    if (do_push) begin
      sp_d = sp_minus2;
    end else if (do_pop) begin
      sp_d = sp_plus2;
    end
    if (int_start) begin
      flags_d = bus.flags_in;
    end
  end

  // Everything is gated by rst_n so an aborted INT2/RTI2 cannot write memory.
  always_comb begin
    addr_w     = '0;
    address    = 32'd0;
    write_data = 32'd0;
    mw         = 1'b0;
    mr         = 1'b0;
    rdata_out  = 32'd0;
    pc_out     = 32'd0;
    pc_load    = 1'b0;
    flags_out  = 4'd0;
    flags_load = 1'b0;
    busy       = 1'b0;
    stack_err  = 1'b0;
    if (rst_n) begin
      if (is_ldd || is_std) begin
        addr_w = bus.ea[ADDR_W-1:0];
      end else if (do_push) begin
        addr_w = sp_q;
      end else if (do_pop) begin
        addr_w = sp_plus2;
      end
      address    = 32'(addr_w);
      mw         = is_std || do_push;
      mr         = is_ldd || do_pop;
      write_data = is_std ? bus.wdata : (do_push ? push_val : 32'd0);
      rdata_out  = mr ? bus.Read_Data : 32'd0;
      pc_load    = ret_pc;
      pc_out     = ret_pc ? bus.Read_Data : 32'd0;
      flags_load = rti_flags;
      flags_out  = rti_flags ? bus.Read_Data[3:0] : 4'd0;
      busy       = int_start || rti_start;
      stack_err  = (do_push && (sp_q == '0)) || (do_pop && (sp_q == SP_RESET));
    end
  end

  assign bus.Address    = address;
  assign bus.Write_Data = write_data;
  assign bus.MW         = mw;
  assign bus.MR         = mr;
  assign bus.rdata_out  = rdata_out;
  assign bus.pc_out     = pc_out;
  assign bus.pc_load    = pc_load;
  assign bus.flags_out  = flags_out;
  assign bus.flags_load = flags_load;
  assign bus.busy       = busy;
  assign bus.sp_out     = sp_q;
  assign bus.stack_err  = stack_err;

endmodule
